// File: rtl/cross_domain_rx.sv
// cross_domain_rx
// Receiving end of a four-phase req/ack bundled-data clock-domain crossing.
// The source holds dataIn stable and raises reqIn; this block synchronizes
// reqIn into clk, captures dataIn, offers the word on a valid/ready interface,
// and raises ackOut only once the local consumer has taken the word. ackOut
// falls after the synchronized request falls.
//
// Parameters:
//   WIDTH        width of the transferred word
//   SYNC_STAGES  flops in the reqIn synchronizer (2..4)
// Ports:
//   clk            block clock
//   reset          synchronous active-high reset
//   reqIn          request level from the source domain (asynchronous)
//   dataIn         bundled data, stable while the request is outstanding
//   ackOut         acknowledge level back to the source, straight from a flop
//   dataOut        captured word (registered)
//   validOut       dataOut holds an unconsumed word
//   readyIn        local consumer accepts when validOut && readyIn
//   protocolError  sticky: reqIn was withdrawn before the acknowledge
module cross_domain_rx #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqIn,
  input  logic [WIDTH-1:0] dataIn,
  output logic             ackOut,
  output logic [WIDTH-1:0] dataOut,
  output logic             validOut,
  input  logic             readyIn,
  output logic             protocolError
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_sync;

  // Only the request level crosses through the synchronizer; dataIn is
  // sampled directly because the handshake guarantees it is settled by the
  // time req_sync is seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], reqIn};
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ackOut        <= 1'b0;
      validOut      <= 1'b0;
      dataOut       <= '0;
      protocolError <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_sync) begin
            dataOut  <= dataIn;
            validOut <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // A withdrawn request is flagged but the held word is still
          // delivered; if acceptance coincides, ACK sees the low request on
          // the next edge and ackOut pulses for a single cycle.
          if (!req_sync) begin
            protocolError <= 1'b1;
          end
          if (readyIn) begin
            validOut <= 1'b0;
            ackOut   <= 1'b1;
            state    <= ACK;
          end
        end
        ACK: begin
          if (!req_sync) begin
            ackOut <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          ackOut   <= 1'b0;
          validOut <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cross_domain_rx.sv
module tb_cross_domain_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqIn;
  logic [31:0] dataIn;
  logic        ackOut;
  logic [31:0] dataOut;
  logic        validOut;
  logic        readyIn;
  logic        protocolError;

  int unsigned errors = 0;
  int unsigned checks = 0;

  cross_domain_rx #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .reqIn        (reqIn),
    .dataIn       (dataIn),
    .ackOut       (ackOut),
    .dataOut      (dataOut),
    .validOut     (validOut),
    .readyIn      (readyIn),
    .protocolError(protocolError)
  );

  always #5 clk = ~clk;

  // Advance one active edge; outputs are then sampled and inputs changed
  // 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reqIn = 1'b1; dataIn = 32'hDEADBEEF; readyIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ackOut, validOut, dataOut} !== 34'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: ack=%b valid=%b data=%h, want all 0", i, ackOut, validOut, dataOut);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (validOut !== (i == 3)) begin
        errors++;
        $display("FAIL reset_release_valid[%0d]: got %b want %b", i, validOut, (i == 3));
      end
    end
    checks++;
    if (dataOut !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_release_data: got %h want deadbeef", dataOut);
    end
    readyIn = 1'b1;
    tick();
    checks++;
    if ({validOut, ackOut} !== 2'b01) begin
      errors++;
      $display("FAIL reset_accept: valid/ack got %b%b want 01", validOut, ackOut);
    end
    reqIn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ackOut !== (i < 3)) begin
        errors++;
        $display("FAIL reset_ack_fall[%0d]: got %b want %b", i, ackOut, (i < 3));
      end
    end
  endtask

  task automatic test_single();
    dataIn = 32'h12345678; readyIn = 1'b1; reqIn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (validOut !== (i == 3) || ackOut !== (i >= 4)) begin
        errors++;
        $display("FAIL single_seq[%0d]: valid=%b ack=%b want valid=%b ack=%b", i, validOut, ackOut, (i == 3), (i >= 4));
      end
      if (i == 3) begin
        checks++;
        if (dataOut !== 32'h12345678) begin
          errors++;
          $display("FAIL single_data: got %h want 12345678", dataOut);
        end
      end
    end
    reqIn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ackOut !== (i < 3) || validOut !== 1'b0) begin
        errors++;
        $display("FAIL single_release[%0d]: ack=%b valid=%b want ack=%b valid=0", i, ackOut, validOut, (i < 3));
      end
    end
    checks++;
    if (dataOut !== 32'h12345678) begin
      errors++;
      $display("FAIL single_data_hold: got %h want 12345678", dataOut);
    end
  endtask

  task automatic test_backpressure();
    dataIn = 32'hA5A50F0F; readyIn = 1'b0; reqIn = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (validOut !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid_rise: got %b want 1", validOut);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (validOut !== 1'b1 || ackOut !== 1'b0 || dataOut !== 32'hA5A50F0F) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ack=%b data=%h want 1 0 a5a50f0f", i, validOut, ackOut, dataOut);
      end
    end
    readyIn = 1'b1;
    tick();
    checks++;
    if ({validOut, ackOut} !== 2'b01) begin
      errors++;
      $display("FAIL bp_accept: valid/ack got %b%b want 01", validOut, ackOut);
    end
    reqIn = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (ackOut !== 1'b0) begin
      errors++;
      $display("FAIL bp_ack_fall: got %b want 0", ackOut);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned sent = 0;
    int unsigned rcvd = 0;
    int unsigned phase = 0;
    int unsigned cyc = 0;
    logic        take;
    logic [31:0] word;
    while ((rcvd < 16 || ackOut !== 1'b0) && cyc < 3000) begin
      readyIn = 1'($urandom_range(0, 1));
      take = validOut && readyIn;
      word = dataOut;
      if (phase == 0) begin
        if (ackOut == 1'b0 && sent < 16) begin
          dataIn = sent;
          reqIn  = 1'b1;
          phase  = 1;
        end
      end else if (ackOut == 1'b1) begin
        reqIn = 1'b0;
        sent++;
        phase = 0;
      end
      tick();
      cyc++;
      if (take) begin
        checks++;
        if (word !== rcvd) begin
          errors++;
          $display("FAIL b2b_word[%0d]: got %0d want %0d", rcvd, word, rcvd);
        end
        rcvd++;
      end
    end
    checks++;
    if (rcvd !== 16 || sent !== 16) begin
      errors++;
      $display("FAIL b2b_count: received %0d sent %0d want 16 16 (cycles %0d)", rcvd, sent, cyc);
    end
    checks++;
    if (protocolError !== 1'b0) begin
      errors++;
      $display("FAIL b2b_protocol_error: got %b want 0", protocolError);
    end
  endtask

  task automatic test_protocol_violation();
    dataIn = 32'hCAFEF00D; readyIn = 1'b0; reqIn = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (validOut !== 1'b1) begin
      errors++;
      $display("FAIL pv_valid: got %b want 1", validOut);
    end
    reqIn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (protocolError !== (i == 3) || validOut !== 1'b1) begin
        errors++;
        $display("FAIL pv_flag[%0d]: perr=%b valid=%b want perr=%b valid=1", i, protocolError, validOut, (i == 3));
      end
    end
    checks++;
    if (dataOut !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL pv_data: got %h want cafef00d", dataOut);
    end
    readyIn = 1'b1;
    tick();
    checks++;
    if ({validOut, ackOut} !== 2'b01) begin
      errors++;
      $display("FAIL pv_accept: valid/ack got %b%b want 01", validOut, ackOut);
    end
    tick();
    checks++;
    if (ackOut !== 1'b0) begin
      errors++;
      $display("FAIL pv_ack_pulse: got %b want 0", ackOut);
    end
    tick(); tick();
    checks++;
    if (protocolError !== 1'b1 || validOut !== 1'b0) begin
      errors++;
      $display("FAIL pv_sticky: perr=%b valid=%b want 1 0", protocolError, validOut);
    end
  endtask

  task automatic test_mid_reset();
    dataIn = 32'h0BADCAFE; readyIn = 1'b1; reqIn = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if (ackOut !== 1'b1) begin
      errors++;
      $display("FAIL mr_in_ack: ack got %b want 1", ackOut);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({ackOut, validOut, protocolError, dataOut} !== 35'd0) begin
      errors++;
      $display("FAIL mr_reset: ack=%b valid=%b perr=%b data=%h want all 0", ackOut, validOut, protocolError, dataOut);
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (validOut !== (i == 3)) begin
        errors++;
        $display("FAIL mr_represent[%0d]: valid got %b want %b", i, validOut, (i == 3));
      end
    end
    checks++;
    if (dataOut !== 32'h0BADCAFE) begin
      errors++;
      $display("FAIL mr_data: got %h want 0badcafe", dataOut);
    end
    tick();
    reqIn = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (ackOut !== 1'b0 || protocolError !== 1'b0) begin
      errors++;
      $display("FAIL mr_finish: ack=%b perr=%b want 0 0", ackOut, protocolError);
    end
  endtask

  initial begin
    reset = 1'b1; reqIn = 1'b0; dataIn = '0; readyIn = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_protocol_violation();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cross_domain_rx.md
# cross_domain_rx

Destination end of a four-phase req/ack bundled-data crossing into the `clk` domain. The source domain holds `dataIn` stable and raises `reqIn`. This block synchronizes `reqIn`, captures `dataIn`, and presents it locally on a valid/ready interface. It raises `ackOut` only after local acceptance, and drops it once the synchronized request falls. It is the receiving counterpart of the team's pulse-synchronizer crossings, used wherever a multi-bit word, not just an enable, must enter a clock domain.

## Interface
- `WIDTH`, 32: bit width of the transferred word.
- `SYNC_STAGES`, 2: flop count in the `reqIn` synchronizer; legal range 2..4.

- `clk`  in  1  single block clock.
- `reset`  in  1  synchronous, active-high reset, sampled on `posedge clk`.
- `reqIn`  in  1  request level from the source domain, asynchronous to `clk`.
- `dataIn`  in  WIDTH  bundled data from the source domain; stable while `reqIn` is high and until `ackOut` is seen high.
- `ackOut`  out  1  acknowledge level to the source domain, driven straight from a flop.
- `dataOut`  out  WIDTH  captured word, registered.
- `validOut`  out  1  `dataOut` holds an unconsumed word.
- `readyIn`  in  1  local consumer accepts the word when `validOut && readyIn`.
- `protocolError`  out  1  sticky flag: `reqIn` was withdrawn before the acknowledge.

## Operation
- Synchronizer:
  - `SYNC_STAGES` flops chained on `reqIn`, all reset to 0.
  - `reqSync` is the last stage.
  - Only `reqIn` is synchronized; `dataIn` is sampled directly and is constrained as a max-delay/false path.
- State machine, encoded in the flops:
  - IDLE: `validOut=0`, `ackOut=0`. If `reqSync=1`, load `dataOut<=dataIn`, set `validOut<=1`, go to HOLD.
  - HOLD: `validOut=1`, `ackOut=0`. If `readyIn=1`, clear `validOut`, set `ackOut<=1`, go to ACK. If `reqSync=0` in HOLD, set `protocolError<=1`; the transfer still completes normally.
  - ACK: `ackOut=1`. If `reqSync=0`, clear `ackOut`, go to IDLE. Otherwise stay.
- `dataOut` is loaded only on the IDLE→HOLD transition and holds its value otherwise, including after consumption.
- `protocolError` is cleared only by `reset`.
- Reset values: state IDLE, all synchronizer flops 0, `ackOut=0`, `validOut=0`, `dataOut=0`, `protocolError=0`.
- Reset mid-operation: all state is discarded. If `reqIn` is still high after reset, the same word is received again as a new transfer. The source protocol tolerates this duplicate; the block does not suppress it.
- There is no buffering: exactly one word is in flight per handshake.

## Timing
- `reqIn` rise to `validOut`, for `SYNC_STAGES=2`:
  - edge k is the first edge that samples `reqIn=1`;
  - `reqSync` goes high after edge k+1;
  - `validOut` and `dataOut` update after edge k+2.
  - In general, latency is `SYNC_STAGES+1` edges.
- Accept:
  - `validOut && readyIn` at edge m drives `validOut` low and `ackOut` high after edge m.
  - If `readyIn` is already high when `validOut` rises, the word is held for exactly one cycle.
- `reqIn` fall to `ackOut` fall:
  - edge p is the first edge that samples `reqIn=0`;
  - `ackOut` goes low after edge p+`SYNC_STAGES`.
- Back-to-back transfers: the earliest next capture is `SYNC_STAGES+1` edges after the source raises `reqIn` again.
- `readyIn` is ignored outside HOLD. `reqSync` rising while in ACK is impossible under protocol, and stays in ACK.
- Simultaneous HOLD events:
  - if `readyIn=1` and `reqSync=0` in the same cycle, the block goes to ACK and sets `protocolError`;
  - the next cycle ACK sees `reqSync=0`, so `ackOut` pulses high for one cycle.

## Test plan
- Reset hold:
  - stimulus: `reset=1` for 3 cycles with `reqIn=1`, `dataIn=32'hDEADBEEF`;
  - response: `ackOut`, `validOut` and `dataOut` all 0 throughout; `validOut` rises 3 edges after reset release with `dataOut=32'hDEADBEEF`.
- Single transfer:
  - stimulus: `dataIn=32'h12345678`, `reqIn` raised, `readyIn=1`;
  - response: `validOut` high for exactly 1 cycle at edge k+2; `ackOut` high from edge k+3; after `reqIn` falls, `ackOut` low 2 edges later, state back in IDLE.
- Backpressure:
  - stimulus: `readyIn=0` for 10 cycles after `validOut` rises, then 1;
  - response: `dataOut` stable, `ackOut=0` for all 10 cycles; `ackOut` rises on the accepting edge.
- Back-to-back:
  - stimulus: 16 transfers with values 0..15, source model honoring four-phase rules, random `readyIn`;
  - response: 16 words delivered in order, no loss or duplicate, `protocolError=0`.
- Protocol violation:
  - stimulus: drop `reqIn` while in HOLD with `readyIn=0`;
  - response: `protocolError=1` and sticky; word still delivered; `ackOut` pulses one cycle after acceptance.
- Mid-transfer reset:
  - stimulus: assert `reset` in ACK with `reqIn` still high;
  - response: `ackOut` drops after the reset edge; the same word is re-presented `SYNC_STAGES+1` edges after reset release.
